param_bus_datapath: RTL and testbench

//  Parametrised next-generation single-bus CPU datapath. It holds a general register array,
//  Y, a 2W-bit Z, HI, LO, IR, MAR, MDR and PC, all sharing one internal bus.

---
 rtl/param_bus_datapath.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_param_bus_datapath.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_bus_datapath.sv
`default_nettype none
// ============================================================================
// Module   : param_bus_datapath
// Purpose  : Single-bus CPU datapath with a general register array, Y, a
//            2W-bit Z, HI, LO, IR, MAR, MDR and PC sharing one internal bus,
//            a single-cycle ALU, and an iterative signed MUL/DIV engine
//            driven by a start/busy/done handshake.
// Ports    : clock, clear (async, active-low)
//            reg_sel/reg_in/BAout       register array access
//            bus_src                    bus source select (0 none, 1 REG,
//                                       2 HI, 3 LO, 4 Zhigh, 5 Zlow, 6 PC,
//                                       7 MDR, 8 IR, 9 MAR, 10 Y, else 0)
//            Yin..PCin, IncPC, read     register load controls
//            alu_op, shift_amt, start   ALU / MUL-DIV controls
//            Mdatain                    memory read data
//            BusMuxOut, PCreg, IRreg, MARreg, busy, done, div_by_zero
// Revision : 1.0  initial release
// ============================================================================
module param_bus_datapath #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                          clock,
  input  logic                          clear,
  input  logic [$clog2(NUM_REGS)-1:0]   reg_sel,
  input  logic                          reg_in,
  input  logic [3:0]                    bus_src,
  input  logic                          BAout,
  input  logic                          Yin,
  input  logic                          Zin,
  input  logic                          HIin,
  input  logic                          LOin,
  input  logic                          IRin,
  input  logic                          MARin,
  input  logic                          MDRin,
  input  logic                          PCin,
  input  logic                          IncPC,
  input  logic                          read,
  input  logic [3:0]                    alu_op,
  input  logic [SHAMT_WIDTH-1:0]        shift_amt,
  input  logic                          start,
  input  logic [DATA_WIDTH-1:0]         Mdatain,
  output logic [DATA_WIDTH-1:0]         BusMuxOut,
  output logic [DATA_WIDTH-1:0]         PCreg,
  output logic [DATA_WIDTH-1:0]         IRreg,
  output logic [DATA_WIDTH-1:0]         MARreg,
  output logic                          busy,
  output logic                          done,
  output logic                          div_by_zero
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_NEG  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Architectural registers
  logic [W-1:0]   gpr_q [NUM_REGS];
  logic [W-1:0]   gpr_d [NUM_REGS];
  logic [W-1:0]   y_q, y_d, hi_q, hi_d, lo_q, lo_d, ir_q, ir_d;
  logic [W-1:0]   mar_q, mar_d, mdr_q, mdr_d, pc_q, pc_d;
  logic [2*W-1:0] z_q, z_d;

  // MUL/DIV engine state
  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0] work_q, work_d;   // MUL: {partial, multiplier}; DIV: {remainder, quotient}
  logic [W-1:0]   bmag_q, bmag_d;
  logic           a_neg_q, a_neg_d, b_neg_q, b_neg_d, is_div_q, is_div_d;
  logic           busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  // Combinational helpers
  logic [W-1:0]       alu_res;
  logic [SHAMT_WIDTH:0] inv_amt;
  logic [W-1:0]       a_mag, b_mag;
  logic [W:0]         mul_sum, div_shift, div_trial;
  logic [2*W-1:0]     step_val, prod_fix, eng_res;
  logic [W-1:0]       quo_fix, rem_fix;
  logic               is_muldiv;

  // --------------------------------------------------------------------------
  // Internal bus
  // --------------------------------------------------------------------------
  always_comb begin
    BusMuxOut = '0;
    case (bus_src)
      4'd1:    BusMuxOut = (BAout && (reg_sel == '0)) ? '0 : gpr_q[reg_sel];
      4'd2:    BusMuxOut = hi_q;
      4'd3:    BusMuxOut = lo_q;
      4'd4:    BusMuxOut = z_q[2*W-1:W];
      4'd5:    BusMuxOut = z_q[W-1:0];
      4'd6:    BusMuxOut = pc_q;
      4'd7:    BusMuxOut = mdr_q;
      4'd8:    BusMuxOut = ir_q;
      4'd9:    BusMuxOut = mar_q;
      4'd10:   BusMuxOut = y_q;
      default: BusMuxOut = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Single-cycle ALU: A = Y, B = bus
  // --------------------------------------------------------------------------
  always_comb begin
    alu_res = '0;
    // Left-shift distance that completes a right rotate (and vice versa);
    // a zero count gives a shift by W, which yields 0 and leaves B unchanged.
    inv_amt = (SHAMT_WIDTH + 1)'(W) - {1'b0, shift_amt};
    case (alu_op)
      OP_ADD:  alu_res = y_q + BusMuxOut;
      OP_SUB:  alu_res = y_q - BusMuxOut;
      OP_AND:  alu_res = y_q & BusMuxOut;
      OP_OR:   alu_res = y_q | BusMuxOut;
      OP_SHR:  alu_res = BusMuxOut >> shift_amt;
      OP_SHRA: alu_res = W'($signed(BusMuxOut) >>> shift_amt);
      OP_SHL:  alu_res = BusMuxOut << shift_amt;
      OP_ROR:  alu_res = (BusMuxOut >> shift_amt) | (BusMuxOut << inv_amt);
      OP_ROL:  alu_res = (BusMuxOut << shift_amt) | (BusMuxOut >> inv_amt);
      OP_NEG:  alu_res = '0 - BusMuxOut;
      OP_NOT:  alu_res = ~BusMuxOut;
      default: alu_res = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Register next-state
  // --------------------------------------------------------------------------
  always_comb begin
    gpr_d = gpr_q;
    if (reg_in) begin
      gpr_d[reg_sel] = BusMuxOut;
    end
    y_d   = Yin   ? BusMuxOut : y_q;
    hi_d  = HIin  ? z_q[2*W-1:W] : hi_q;
    lo_d  = LOin  ? z_q[W-1:0]   : lo_q;
    ir_d  = IRin  ? BusMuxOut : ir_q;
    mar_d = MARin ? BusMuxOut : mar_q;
    mdr_d = MDRin ? (read ? Mdatain : BusMuxOut) : mdr_q;
    if (PCin) begin
      pc_d = BusMuxOut;
    end else if (IncPC) begin
      pc_d = pc_q + W'(1);
    end else begin
      pc_d = pc_q;
    end
  end

  // --------------------------------------------------------------------------
  // MUL/DIV engine: unsigned radix-2 iteration on magnitudes, sign fix-up
  // applied in the final RUN cycle as the result is written to Z.
  // --------------------------------------------------------------------------
  always_comb begin
    is_muldiv = (alu_op == OP_MUL) || (alu_op == OP_DIV);
    a_mag     = y_q[W-1] ? ('0 - y_q) : y_q;
    b_mag     = BusMuxOut[W-1] ? ('0 - BusMuxOut) : BusMuxOut;

    // Shift-add multiply step: add B when the multiplier LSB is set, shift right.
    mul_sum   = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, bmag_q} : '0);
    // Restoring divide step: shift remainder left pulling in the next dividend bit.
    div_shift = work_q[2*W-1:W-1];
    div_trial = div_shift - {1'b0, bmag_q};
    if (is_div_q) begin
      step_val = div_trial[W] ? {div_shift[W-1:0], work_q[W-2:0], 1'b0}
                              : {div_trial[W-1:0], work_q[W-2:0], 1'b1};
    end else begin
      step_val = {mul_sum, work_q[W-1:1]};
    end

    prod_fix = (a_neg_q ^ b_neg_q) ? ('0 - work_q) : work_q;
    // A zero divisor leaves the dividend magnitude as remainder, so the
    // dividend-sign fix-up reproduces A; only the quotient needs forcing.
    if (bmag_q == '0) begin
      quo_fix = '1;
    end else begin
      quo_fix = (a_neg_q ^ b_neg_q) ? ('0 - work_q[W-1:0]) : work_q[W-1:0];
    end
    rem_fix = a_neg_q ? ('0 - work_q[2*W-1:W]) : work_q[2*W-1:W];
    eng_res = is_div_q ? {rem_fix, quo_fix} : prod_fix;

    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    bmag_d   = bmag_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    is_div_d = is_div_q;
    dbz_d    = dbz_q;
    z_d      = z_q;

    case (state_q)
      S_RUN: begin
        if (cnt_q == CNT_W'(W)) begin
          z_d     = eng_res;
          state_d = S_DONE;
          if (is_div_q && (bmag_q == '0)) begin
            dbz_d = 1'b1;
          end
        end else begin
          work_d = step_val;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // IDLE and DONE both return to IDLE unless a new operation launches.
        state_d = S_IDLE;
        if (Zin && !is_muldiv) begin
          z_d = {{W{1'b0}}, alu_res};
        end
        if (start && is_muldiv) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          work_d   = {{W{1'b0}}, a_mag};
          bmag_d   = b_mag;
          a_neg_d  = y_q[W-1];
          b_neg_d  = BusMuxOut[W-1];
          is_div_d = (alu_op == OP_DIV);
          dbz_d    = 1'b0;
        end
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= '0;
      end
      y_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      ir_q     <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      pc_q     <= '0;
      z_q      <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      bmag_q   <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      gpr_q    <= gpr_d;
      y_q      <= y_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ir_q     <= ir_d;
      mar_q    <= mar_d;
      mdr_q    <= mdr_d;
      pc_q     <= pc_d;
      z_q      <= z_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      bmag_q   <= bmag_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign PCreg       = pc_q;
  assign IRreg       = ir_q;
  assign MARreg      = mar_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_param_bus_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_bus_datapath
// Purpose  : Directed self-checking bench for param_bus_datapath; a 32-bit,
//            16-register instance plus a 16-bit, 8-register instance.
// Revision : 1.0  initial release
// ============================================================================
module tb_param_bus_datapath;

  logic        clock = 1'b0;
  logic        clear;

  // 32-bit instance
  logic [3:0]  reg_sel;
  logic        reg_in, BAout, Yin, Zin, HIin, LOin, IRin, MARin, MDRin, PCin, IncPC, read, start;
  logic [3:0]  bus_src, alu_op;
  logic [4:0]  shift_amt;
  logic [31:0] Mdatain, BusMuxOut, PCreg, IRreg, MARreg;
  logic        busy, done, div_by_zero;

  // 16-bit instance
  logic [2:0]  b_reg_sel;
  logic        b_reg_in, b_BAout, b_Yin, b_Zin, b_HIin, b_LOin, b_IRin, b_MARin, b_MDRin, b_PCin;
  logic        b_IncPC, b_read, b_start;
  logic [3:0]  b_bus_src, b_alu_op;
  logic [3:0]  b_shift_amt;
  logic [15:0] b_Mdatain, b_BusMuxOut, b_PCreg, b_IRreg, b_MARreg;
  logic        b_busy, b_done, b_div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  param_bus_datapath #(.DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .clock(clock), .clear(clear), .reg_sel(reg_sel), .reg_in(reg_in), .bus_src(bus_src),
    .BAout(BAout), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin), .PCin(PCin), .IncPC(IncPC), .read(read),
    .alu_op(alu_op), .shift_amt(shift_amt), .start(start), .Mdatain(Mdatain),
    .BusMuxOut(BusMuxOut), .PCreg(PCreg), .IRreg(IRreg), .MARreg(MARreg),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  param_bus_datapath #(.DATA_WIDTH(16), .NUM_REGS(8)) dut16 (
    .clock(clock), .clear(clear), .reg_sel(b_reg_sel), .reg_in(b_reg_in), .bus_src(b_bus_src),
    .BAout(b_BAout), .Yin(b_Yin), .Zin(b_Zin), .HIin(b_HIin), .LOin(b_LOin), .IRin(b_IRin),
    .MARin(b_MARin), .MDRin(b_MDRin), .PCin(b_PCin), .IncPC(b_IncPC), .read(b_read),
    .alu_op(b_alu_op), .shift_amt(b_shift_amt), .start(b_start), .Mdatain(b_Mdatain),
    .BusMuxOut(b_BusMuxOut), .PCreg(b_PCreg), .IRreg(b_IRreg), .MARreg(b_MARreg),
    .busy(b_busy), .done(b_done), .div_by_zero(b_div_by_zero)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_ctl();
    reg_in = 0; BAout = 0; Yin = 0; Zin = 0; HIin = 0; LOin = 0; IRin = 0; MARin = 0;
    MDRin = 0; PCin = 0; IncPC = 0; read = 0; start = 0; bus_src = 0; alu_op = 0;
    shift_amt = 0; reg_sel = 0;
  endtask

  task automatic peek(input logic [3:0] src, output logic [31:0] val);
    bus_src = src;
    #1;
    val = BusMuxOut;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; read = 1; MDRin = 1;
    tick();
    read = 0; MDRin = 0;
  endtask

  task automatic load_y(input logic [31:0] v);
    load_mdr(v);
    bus_src = 7; Yin = 1;
    tick();
    Yin = 0; bus_src = 0;
  endtask

  // Y <- a, MDR <- b, launch op with B taken from MDR over the bus.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    load_y(a);
    load_mdr(b);
    bus_src = 7; alu_op = op; start = 1;
    tick();
    start = 0; alu_op = 0; bus_src = 0;
  endtask

  // Cycles counted from the edge that sampled start; bounded.
  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  typedef struct {
    logic [31:0] y;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  amt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          cyc;
    int          ndone;

    idle_ctl();
    Mdatain = 0;
    b_reg_sel = 0; b_reg_in = 0; b_BAout = 0; b_Yin = 0; b_Zin = 0; b_HIin = 0; b_LOin = 0;
    b_IRin = 0; b_MARin = 0; b_MDRin = 0; b_PCin = 0; b_IncPC = 0; b_read = 0; b_start = 0;
    b_bus_src = 0; b_alu_op = 0; b_shift_amt = 0; b_Mdatain = 0;

    // ---- reset ----
    clear = 0;
    tick(); tick();
    check_eq("rst_pc",   PCreg, 0);
    check_eq("rst_busy", {busy, done, div_by_zero}, 0);
    clear = 1;
    tick();
    peek(0, v); check_eq("rst_bus0", v, 0);

    // ---- register moves ----
    load_mdr(32'h1234_5678);
    bus_src = 7; reg_sel = 5; reg_in = 1; tick(); reg_in = 0;
    peek(1, v); check_eq("r5_read", v, 32'h1234_5678);
    load_mdr(32'h7);
    bus_src = 7; reg_sel = 0; reg_in = 1; tick(); reg_in = 0;
    BAout = 1; peek(1, v); check_eq("r0_baout", v, 0);
    BAout = 0; peek(1, v); check_eq("r0_plain", v, 7);
    reg_sel = 0;

    // ---- PC / IR / MAR ----
    load_mdr(32'hFFFF_FFFF);
    bus_src = 7; PCin = 1; IRin = 1; MARin = 1; tick(); PCin = 0; IRin = 0; MARin = 0;
    check_eq("pc_load", PCreg, 32'hFFFF_FFFF);
    check_eq("ir_load", IRreg, 32'hFFFF_FFFF);
    check_eq("mar_load", MARreg, 32'hFFFF_FFFF);
    IncPC = 1; tick(); IncPC = 0;
    check_eq("pc_wrap", PCreg, 0);
    load_mdr(32'hA5A5_0001);
    bus_src = 7; PCin = 1; IncPC = 1; tick(); PCin = 0; IncPC = 0;
    check_eq("pc_prio", PCreg, 32'hA5A5_0001);

    // ---- single-cycle ALU ----
    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 4'd0,  5'd0, 32'h0000_0000};
    vecs[1]  = '{32'h0000_0005, 32'h0000_0007, 4'd1,  5'd0, 32'hFFFF_FFFE};
    vecs[2]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2,  5'd0, 32'hF000_F000};
    vecs[3]  = '{32'h0000_F0F0, 32'h0F00_0000, 4'd3,  5'd0, 32'h0F00_F0F0};
    vecs[4]  = '{32'h0000_0000, 32'h8000_0000, 4'd4,  5'd4, 32'h0800_0000};
    vecs[5]  = '{32'h0000_0000, 32'h8000_0000, 4'd5,  5'd4, 32'hF800_0000};
    vecs[6]  = '{32'h0000_0000, 32'h8000_0001, 4'd6,  5'd1, 32'h0000_0002};
    vecs[7]  = '{32'h0000_0000, 32'h0000_0003, 4'd7,  5'd1, 32'h8000_0001};
    vecs[8]  = '{32'h0000_0000, 32'h8000_0001, 4'd8,  5'd1, 32'h0000_0003};
    vecs[9]  = '{32'h0000_0000, 32'h1234_5678, 4'd8,  5'd0, 32'h1234_5678};
    vecs[10] = '{32'h0000_0000, 32'h0000_0005, 4'd9,  5'd0, 32'hFFFF_FFFB};
    vecs[11] = '{32'h0000_0000, 32'h0F0F_0F0F, 4'd10, 5'd0, 32'hF0F0_F0F0};
    for (int i = 0; i < 12; i++) begin
      load_y(vecs[i].y);
      load_mdr(vecs[i].b);
      bus_src = 7; alu_op = vecs[i].op; shift_amt = vecs[i].amt; Zin = 1;
      tick();
      Zin = 0;
      peek(5, v); check_eq($sformatf("alu%0d_zlo", i), v, vecs[i].exp);
      peek(4, v); check_eq($sformatf("alu%0d_zhi", i), v, 0);
      alu_op = 0; shift_amt = 0;
    end

    // Zin with a MUL op must not touch Z (Z low currently 0xF0F0F0F0)
    bus_src = 7; alu_op = 11; Zin = 1; tick(); Zin = 0; alu_op = 0;
    peek(5, v); check_eq("zin_mulop", v, 32'hF0F0_F0F0);
    check_eq("zin_mulop_busy", busy, 0);

    // ---- MUL -3 * 7 ----
    launch(32'hFFFF_FFFD, 32'h0000_0007, 4'd11);
    check_eq("mul_busy0", {busy, done}, 2'b10);
    wait_done(0, cyc);
    check_eq("mul_latency", cyc, 33);
    check_eq("mul_busy_at_done", busy, 0);
    peek(4, v); check_eq("mul_zhi", v, 32'hFFFF_FFFF);
    peek(5, v); check_eq("mul_zlo", v, 32'hFFFF_FFEB);
    HIin = 1; LOin = 1; tick(); HIin = 0; LOin = 0;
    check_eq("done_pulse", done, 0);
    peek(2, v); check_eq("hi", v, 32'hFFFF_FFFF);
    peek(3, v); check_eq("lo", v, 32'hFFFF_FFEB);

    // ---- DIV -17 / 5 with hazards while busy ----
    launch(32'hFFFF_FFEF, 32'h0000_0005, 4'd12);
    bus_src = 7; alu_op = 12; start = 1;
    tick(); tick();
    start = 0; alu_op = 0; Zin = 1;
    tick();
    Zin = 0;
    peek(5, v); check_eq("zin_while_busy", v, 32'hFFFF_FFEB);
    wait_done(3, cyc);
    check_eq("div_latency", cyc, 33);
    peek(5, v); check_eq("div_q", v, 32'hFFFF_FFFD);
    peek(4, v); check_eq("div_r", v, 32'hFFFF_FFFE);
    check_eq("div_dbz", div_by_zero, 0);
    tick();

    // ---- DIV 17 / -5 ----
    launch(32'h0000_0011, 32'hFFFF_FFFB, 4'd12);
    wait_done(0, cyc);
    peek(5, v); check_eq("div2_q", v, 32'hFFFF_FFFD);
    peek(4, v); check_eq("div2_r", v, 32'h0000_0002);
    tick();

    // ---- DIV -100 / 0 ----
    launch(32'hFFFF_FF9C, 32'h0000_0000, 4'd12);
    wait_done(0, cyc);
    check_eq("dz_latency", cyc, 33);
    peek(5, v); check_eq("dz_q", v, 32'hFFFF_FFFF);
    peek(4, v); check_eq("dz_r", v, 32'hFFFF_FF9C);
    check_eq("dz_flag", div_by_zero, 1);
    tick(); tick();
    check_eq("dz_sticky", div_by_zero, 1);

    // ---- next accepted start clears the flag ----
    launch(32'h0000_0002, 32'h0000_0003, 4'd11);
    check_eq("dz_cleared", div_by_zero, 0);
    wait_done(0, cyc);
    peek(5, v); check_eq("mul2_zlo", v, 32'h0000_0006);
    tick();

    // ---- clear during RUN ----
    launch(32'h0000_0006, 32'h0000_0007, 4'd11);
    for (int i = 0; i < 9; i++) tick();
    check_eq("abort_busy_before", busy, 1);
    clear = 0;
    #2;
    check_eq("abort_flags", {busy, done, div_by_zero}, 0);
    check_eq("abort_pc", PCreg, 0);
    check_eq("abort_ir_mar", {IRreg, MARreg}, 0);
    peek(5, v); check_eq("abort_zlo", v, 0);
    peek(1, v); check_eq("abort_r5", v, 0);
    clear = 1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
    end
    check_eq("abort_no_done", ndone, 0);
    peek(4, v); check_eq("abort_zhi", v, 0);

    // ---- 16-bit / 8-register instance: 0x7FFF * 0x7FFF ----
    b_Mdatain = 16'h7FFF; b_read = 1; b_MDRin = 1; tick(); b_read = 0; b_MDRin = 0;
    b_bus_src = 7; b_Yin = 1; tick(); b_Yin = 0;
    b_alu_op = 11; b_start = 1; tick(); b_start = 0; b_alu_op = 0;
    cyc = 0;
    while (!b_done && cyc < 100) begin
      tick();
      cyc++;
    end
    check_eq("w16_latency", cyc, 17);
    b_bus_src = 4; #1; check_eq("w16_zhi", b_BusMuxOut, 16'h3FFF);
    b_bus_src = 5; #1; check_eq("w16_zlo", b_BusMuxOut, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
